// File: rtl/window_pkg.sv
// Shared definitions for the windowed min/max reducer.
//   DEFAULT_WIDTH : default sample width used by the top and the comparator
//   state_t       : FSM state type, with encodings S_IDLE / S_ACCUM / S_HOLD
package window_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACCUM = 2'd1;
  localparam state_t S_HOLD  = 2'd2;

endpackage

// File: rtl/window_min_max_compare.sv
// Unsigned magnitude comparator, WIDTH-parameterised.
// Ports:
//   a, b : operands (unsigned)
//   lt   : a <  b
//   eq   : a == b
//   gt   : a >  b
module compare
  import window_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/window_min_max.sv
// Streaming window reducer: accepts WIN_LEN unsigned samples over a valid/ready handshake
// and presents the window's min, max and an all-equal flag on a second valid/ready handshake.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : sample valid;  in_ready : block can accept (low only while holding a result)
//   in_data    : sample value
//   out_valid  : result valid;  out_ready : sink takes the result
//   out_min    : smallest sample of the last completed window
//   out_max    : largest sample of the last completed window
//   out_all_eq : every sample of the last completed window was equal
// WIN_LEN must be >= 1.
module window_min_max
  import window_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned WIN_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic             out_all_eq
);

  localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   min_q, min_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic               all_eq_q, all_eq_d;
  logic [WIDTH-1:0]   out_min_q, out_min_d;
  logic [WIDTH-1:0]   out_max_q, out_max_d;
  logic               out_all_eq_q, out_all_eq_d;

  logic min_lt, min_eq, min_gt;
  logic max_lt, max_eq, max_gt;
  logic in_xfer;

  compare #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (min_q),
    .lt (min_lt),
    .eq (min_eq),
    .gt (min_gt)
  );

  compare #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .lt (max_lt),
    .eq (max_eq),
    .gt (max_gt)
  );

  // Comparator outputs that the reduction does not need.
  logic unused_cmp;
  assign unused_cmp = ^{min_gt, max_lt, max_eq};

  assign in_xfer = in_valid & in_ready;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      all_eq_q     <= 1'b0;
      out_min_q    <= '0;
      out_max_q    <= '0;
      out_all_eq_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      all_eq_q     <= all_eq_d;
      out_min_q    <= out_min_d;
      out_max_q    <= out_max_d;
      out_all_eq_q <= out_all_eq_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    min_d        = min_q;
    max_d        = max_q;
    all_eq_d     = all_eq_q;
    out_min_d    = out_min_q;
    out_max_d    = out_max_q;
    out_all_eq_d = out_all_eq_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          min_d    = in_data;
          max_d    = in_data;
          all_eq_d = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = (WIN_LEN == 1) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_xfer) begin
          if (min_lt) min_d = in_data;
          if (max_gt) max_d = in_data;
          // Equality is judged against the min as it stood before this sample.
          all_eq_d = all_eq_q & min_eq;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == CNT_W'(WIN_LEN)) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Publish the result only on window completion so the outputs keep the
    // previous window's values while the next one accumulates.
    if ((state_d == S_HOLD) && (state_q != S_HOLD)) begin
      out_min_d    = min_d;
      out_max_d    = max_d;
      out_all_eq_d = all_eq_d;
    end
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state_q != S_HOLD);
    out_valid = (state_q == S_HOLD);
  end

  assign out_min    = out_min_q;
  assign out_max    = out_max_q;
  assign out_all_eq = out_all_eq_q;

endmodule
